// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner: one-cold column ring, per-sample debounce FSM and a
// 16-bit shift-in entry register (newest nibble in hex[3:0]).
module keypad_hex_entry #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CNT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [15:0] hex,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        pressed
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_CNT);
    // Nibble at index {row, col} holds the key legend at that position.
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    logic [3:0]    row_meta_q;
    logic [3:0]    rs_q;
    logic [SW-1:0] dwell_q;
    logic [3:0]    col_q;
    state_t        state_q;
    logic [1:0]    cand_row_q;
    logic [DW-1:0] deb_cnt_q;
    logic [DW-1:0] rel_cnt_q;
    logic [15:0]   hex_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          pressed_q;

    logic          sample;
    logic          hit;
    logic          accept;
    logic [1:0]    hit_row;
    logic [1:0]    col_idx;
    logic [3:0]    code_d;
    logic [3:0]    col_rot_d;
    logic [DW-1:0] deb_inc_d;
    logic [DW-1:0] rel_inc_d;

    always_comb begin
        hit     = 1'b1;
        hit_row = 2'd0;
        // Only a single low row is a hit; ghosted or multi-key patterns read as none.
        case (rs_q)
            4'b1110: hit_row = 2'd0;
            4'b1101: hit_row = 2'd1;
            4'b1011: hit_row = 2'd2;
            4'b0111: hit_row = 2'd3;
            default: hit     = 1'b0;
        endcase

        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase

        code_d    = KEYMAP[{hit_row, col_idx, 2'b00} +: 4];
        col_rot_d = {col_q[2:0], col_q[3]};
        deb_inc_d = deb_cnt_q + 1'b1;
        rel_inc_d = rel_cnt_q + 1'b1;
        sample    = (dwell_q == DWELL_LAST);

        accept = 1'b0;
        if (sample && hit) begin
            if (state_q == IDLE && DEBOUNCE_CNT == 1) begin
                accept = 1'b1;
            end
            if (state_q == DEBOUNCE && hit_row == cand_row_q && deb_inc_d == DEB_TARGET) begin
                accept = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            rs_q        <= 4'hF;
            dwell_q     <= '0;
            col_q       <= 4'b1110;
            state_q     <= IDLE;
            cand_row_q  <= 2'd0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            hex_q       <= 16'h0000;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            pressed_q   <= 1'b0;
        end else begin
            row_meta_q  <= row;
            rs_q        <= row_meta_q;
            key_valid_q <= 1'b0;
            dwell_q     <= sample ? '0 : dwell_q + 1'b1;

            // The column only moves on a sample evaluated in (or returning to) IDLE.
            if (sample) begin
                case (state_q)
                    IDLE: begin
                        if (hit) begin
                            cand_row_q <= hit_row;
                            deb_cnt_q  <= DW'(1);
                            rel_cnt_q  <= '0;
                            state_q    <= accept ? HELD : DEBOUNCE;
                        end else begin
                            col_q <= col_rot_d;
                        end
                    end
                    DEBOUNCE: begin
                        if (hit && hit_row == cand_row_q) begin
                            deb_cnt_q <= deb_inc_d;
                            if (accept) begin
                                state_q   <= HELD;
                                rel_cnt_q <= '0;
                            end
                        end else begin
                            state_q   <= IDLE;
                            deb_cnt_q <= '0;
                            col_q     <= col_rot_d;
                        end
                    end
                    HELD: begin
                        if (hit) begin
                            rel_cnt_q <= '0;
                        end else if (rel_inc_d == DEB_TARGET) begin
                            rel_cnt_q <= '0;
                            deb_cnt_q <= '0;
                            pressed_q <= 1'b0;
                            state_q   <= IDLE;
                            col_q     <= col_rot_d;
                        end else begin
                            rel_cnt_q <= rel_inc_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (accept) begin
                key_valid_q <= 1'b1;
                key_code_q  <= code_d;
                pressed_q   <= 1'b1;
            end

            if (clear) begin
                hex_q <= 16'h0000;
            end else if (accept) begin
                hex_q <= {hex_q[11:0], code_d};
            end
        end
    end

    assign col       = col_q;
    assign hex       = hex_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign pressed   = pressed_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Keypad entry bench: a switch-matrix keypad model drives the rows, a scoreboard
// of expected accepts is checked by a monitor whenever key_valid pulses.
module tb_keypad_hex_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    // Physical legend, index = row*4 + column.
    localparam logic [3:0] LAYOUT [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'h0, 4'hF, 4'hE, 4'hD};

    typedef struct {
        logic [3:0]  code;
        logic [15:0] hex;
        logic [3:0]  col;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] hex;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        pressed;
    logic [15:0] key_down = 16'h0000;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] model_hex = 16'h0000;
    int          compared = 0;
    int          mismatched = 0;
    int          pulses = 0;
    int          expected_pulses = 0;

    always #5 clk = ~clk;

    // A closed switch pulls its row low only while its column is driven low.
    assign row = {~|(key_down[15:12] & ~col), ~|(key_down[11:8] & ~col),
                  ~|(key_down[7:4]   & ~col), ~|(key_down[3:0]  & ~col)};

    keypad_hex_entry #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .clear    (clear),
        .col      (col),
        .hex      (hex),
        .key_code (key_code),
        .key_valid(key_valid),
        .pressed  (pressed)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic int key_pos(input logic [3:0] code);
        key_pos = 0;
        for (int i = 0; i < 16; i++) begin
            if (LAYOUT[i] == code) key_pos = i;
        end
    endfunction

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (c % 4));
    endfunction

    // Reference: every accepted key shifts into the entry, clear wins over the shift.
    task automatic expect_key(input logic [3:0] code, input bit clr);
        exp_t e;
        model_hex = clr ? 16'h0000 : {model_hex[11:0], code};
        e.code = code;
        e.hex  = model_hex;
        e.col  = col_drive(key_pos(code) % 4);
        sb_q.push_back(e);
        expected_pulses++;
    endtask

    task automatic wait_pressed(input string name, input logic want, input int budget);
        int n;
        n = 0;
        while (pressed !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pressed !== want) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: actual pressed=%0b required %0b within %0d cycles",
                     name, pressed, want, budget);
        end
    endtask

    task automatic press_good(input logic [3:0] code, input bit clr);
        int p;
        p = key_pos(code);
        expect_key(code, clr);
        clear = clr;
        key_down[p] = 1'b1;
        wait_pressed("press", 1'b1, 200);
        clear = 1'b0;
        key_down[p] = 1'b0;
        wait_pressed("release", 1'b0, 100);
        check("ring_resume", col, col_drive((p % 4) + 1));
        repeat ($urandom_range(0, 5)) @(negedge clk);
    endtask

    task automatic press_bounce(input logic [3:0] code, input int hold);
        logic [3:0] c0;
        int p;
        p = key_pos(code);
        key_down[p] = 1'b1;
        repeat (hold) @(negedge clk);
        key_down[p] = 1'b0;
        repeat (14) @(negedge clk);
        check("bounce_hex", hex, model_hex);
        check("bounce_pressed", pressed, 0);
        c0 = col;
        repeat (SCAN_DIV) @(negedge clk);
        check("bounce_rotate", col != c0, 1);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_hex = 16'h0000;
        check("clear_hex", hex, model_hex);
    endtask

    always @(negedge clk) begin
        if (!reset && key_valid) begin
            pulses++;
            $display("key_valid: key_code=%h hex=%h col=%b", key_code, hex, col);
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_pulse: actual key_code %h required no pulse", key_code);
            end else begin
                mon_e = sb_q.pop_front();
                check("key_code", key_code, mon_e.code);
                check("hex", hex, mon_e.hex);
                check("col_frozen", col, mon_e.col);
                check("pressed_on_accept", pressed, 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] c0;
        int p;
        int sel;
        #1 reset = 1'b1;
        #1;
        check("rst_col", col, 4'b1110);
        check("rst_hex", hex, 16'h0000);
        check("rst_valid", key_valid, 0);
        check("rst_pressed", pressed, 0);
        check("rst_code", key_code, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            check("ring", col, col_drive(k / SCAN_DIV));
            @(negedge clk);
        end

        // Single key 5, then the 1,2,A,F,7 sequence with overflow.
        press_good(4'h5, 1'b0);
        clear_pulse();
        press_good(4'h1, 1'b0);
        press_good(4'h2, 1'b0);
        press_good(4'hA, 1'b0);
        press_good(4'hF, 1'b0);
        press_good(4'h7, 1'b0);
        check("overflow_hex", hex, 16'h2AF7);

        press_bounce(4'h0, 8);

        // Chattering release on key 9: none, hit, none, none, none.
        p = key_pos(4'h9);
        expect_key(4'h9, 1'b0);
        key_down[p] = 1'b1;
        wait_pressed("chatter_press", 1'b1, 200);
        key_down[p] = 1'b0;
        repeat (SCAN_DIV) @(negedge clk);
        key_down[p] = 1'b1;
        repeat (SCAN_DIV) @(negedge clk);
        key_down[p] = 1'b0;
        repeat (2 * SCAN_DIV) @(negedge clk);
        check("chatter_still_held", pressed, 1);
        repeat (SCAN_DIV) @(negedge clk);
        check("chatter_released", pressed, 0);
        check("chatter_ring", col, 4'b0111);

        // Ghosting: keys 1 and 7 share column 0.
        key_down[0] = 1'b1;
        key_down[8] = 1'b1;
        repeat (20) @(negedge clk);
        c0 = col;
        repeat (SCAN_DIV) @(negedge clk);
        check("ghost_rotate", col != c0, 1);
        repeat (20) @(negedge clk);
        check("ghost_pressed", pressed, 0);
        key_down = 16'h0000;
        repeat (8) @(negedge clk);

        // Clear coinciding with the accept of D, then key 3.
        clear_pulse();
        press_good(4'h1, 1'b0);
        press_good(4'h2, 1'b0);
        press_good(4'hA, 1'b0);
        press_good(4'hF, 1'b0);
        check("pre_clear_hex", hex, 16'h12AF);
        press_good(4'hD, 1'b1);
        press_good(4'h3, 1'b0);

        // Reset mid-dwell with key 5 held: it must be accepted again afterwards.
        p = key_pos(4'h5);
        expect_key(4'h5, 1'b0);
        key_down[p] = 1'b1;
        wait_pressed("hold_press", 1'b1, 200);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_col", col, 4'b1110);
        check("mid_rst_hex", hex, 16'h0000);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_pressed", pressed, 0);
        model_hex = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
        expect_key(4'h5, 1'b0);
        wait_pressed("repress", 1'b1, 200);
        key_down[p] = 1'b0;
        wait_pressed("repress_release", 1'b0, 100);
        repeat (4) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      press_good(4'($urandom_range(0, 15)), 1'b0);
            else if (sel <= 7) press_bounce(4'($urandom_range(0, 15)), $urandom_range(1, 8));
            else if (sel == 8) clear_pulse();
            else               press_good(4'($urandom_range(0, 15)), 1'b1);
        end

        repeat (10) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        check("pulse_count", pulses, expected_pulses);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_hex_entry.md
Name: keypad_hex_entry

Overview:
- Input-side counterpart of the 4-digit seven-segment display path.
- Scans a 4x4 hex keypad (Pmod KYPD style), debounces each press, decodes it to a nibble and shifts it into a 16-bit hex entry register.
- The 16-bit register feeds the display's hex bus, or CPU input, directly.
- Column drive uses a one-cold ring pattern, the mirror of the display anode scan.

Parameters:
- SCAN_DIV, 100000: clk cycles each column is driven (dwell); legal minimum is 4.
- DEBOUNCE_CNT, 10: consecutive identical row samples needed to accept a press or a release; legal minimum is 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- row  in  4  keypad rows, active-low (pulled up); asynchronous to clk
- clear  in  1  synchronous; zeroes the entry register
- col  out  4  keypad column drive, active-low, exactly one bit low
- hex  out  16  entry register; newest key in hex[3:0]
- key_code  out  4  last accepted key value
- key_valid  out  1  one-cycle pulse per accepted press
- pressed  out  1  high while a key is accepted and not yet released

Behaviour:
- Reset values: col=4'b1110, hex=16'h0000, key_code=4'h0, key_valid=0, pressed=0, FSM=IDLE, all counters 0, synchronizer flops all 1s.
- Row synchronizer: row passes through a 2-flop synchronizer; the result is rs.
- Sample point: rs is sampled on the last cycle of each dwell (dwell counter = SCAN_DIV-1). Only that sample is evaluated.
- Sample classification:
  - "hit": exactly one rs bit is low.
  - "none": rs = 4'hF.
  - Two or more bits low is treated as "none" (ghosting and multi-key are rejected).
- Column ring: in IDLE the column advances after each sample, 1110 -> 1101 -> 1011 -> 0111 -> 1110. In DEBOUNCE and HELD the column is frozen.
- Key map. Row r uses rs[r]; column c is the position of the low col bit.
  - r0: c0..c3 = 1, 2, 3, A
  - r1: c0..c3 = 4, 5, 6, B
  - r2: c0..c3 = 7, 8, 9, C
  - r3: c0..c3 = 0, F, E, D
- FSM states: IDLE, DEBOUNCE, HELD.
- IDLE:
  - On a hit: latch candidate (col, row), set the debounce count to 1 and go to DEBOUNCE.
  - If DEBOUNCE_CNT = 1, accept immediately instead.
- DEBOUNCE:
  - Each sample matching the candidate row increments the count.
  - Any other sample (none, or a different row) returns to IDLE; the column advances normally.
  - When the count reaches DEBOUNCE_CNT: accept and go to HELD.
- Accept (single clock edge, on the cycle after the qualifying sample):
  - key_valid=1 for exactly one cycle.
  - key_code = decoded value.
  - hex <= {hex[11:0], code}.
  - pressed=1.
- HELD:
  - Each "none" sample increments the release count; any hit resets it to 0.
  - When the release count reaches DEBOUNCE_CNT: pressed=0, go to IDLE; the column advances on that sample.
  - A held key never re-triggers (no auto-repeat).
- Shift overflow: the oldest nibble hex[15:12] is discarded. No saturation and no flag.
- clear:
  - Sets hex=16'h0000 on the next edge in any state; it does not affect the FSM, pressed or key_code.
  - If clear coincides with an accept, clear wins: hex=16'h0000. key_valid and key_code still update.
- Reset mid-operation: everything returns to reset values immediately. A key still held after reset deasserts is a new press and is accepted again after full debounce.
- Latency: an accept occurs DEBOUNCE_CNT samples (same column) after the first hit, plus 1 cycle. The synchronizer adds 2 cycles before row changes are visible.

Test Plan:
- Config for all scenarios: SCAN_DIV=4, DEBOUNCE_CNT=3.
- Reset check: assert reset mid-dwell -> col=1110, hex=0000, key_valid=0, pressed=0 asynchronously. After release, col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, 4 cycles each.
- Single key: model holds row1 low while col=1101 (key 5) -> col freezes at 1101. Exactly one key_valid pulse, 1 cycle after the 3rd consecutive hit sample; key_code=5, hex=0005, pressed=1. Release -> pressed=0 after 3 none-samples, then rotation resumes.
- Sequence and overflow: enter 1, 2, A, F, 7 -> hex goes 0001, 0012, 012A, 12AF, 2AF7. Exactly 5 key_valid pulses.
- Bounce rejection:
  - Press key 0 (row3, col0) for 2 samples, then release -> no key_valid, FSM back to IDLE, hex unchanged.
  - Chattering release while in HELD (none, hit, none, none, none) -> pressed stays 1 until 3 consecutive none-samples; no second pulse.
- Ghosting: rows 0 and 2 low simultaneously on col0 -> never accepted, rotation continues.
- clear: hex=12AF, then clear asserted on the same cycle as the accept of key D -> hex=0000, key_valid=1, key_code=D. Next key 3 -> hex=0003.
